// File: rtl/alu_exec_unit.sv
// alu_exec_unit: single-cycle arith/logic and iterative one-bit-per-cycle shifter with ready/out_valid handshake
module alu_exec_unit #(
   parameter int N = 32,
   parameter int S = 5
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         enable_arith,
   input  logic         enable_shift,
   input  logic [N-1:0] aluin1,
   input  logic [N-1:0] aluin2,
   input  logic [2:0]   operation_in,
   input  logic [2:0]   opselect_in,
   input  logic [S-1:0] shift_number,
   output logic         ready,
   output logic [N-1:0] aluout,
   output logic         carry,
   output logic         out_valid
);
   typedef enum logic {IDLE, SHIFT} state_t;
   state_t       state_q, state_d;
   logic [N-1:0] aluout_q, aluout_d, work_q, work_d;
   logic         carry_q, carry_d, out_valid_q, out_valid_d;
   logic [S-1:0] cnt_q, cnt_d;
   logic [1:0]   sop_q, sop_d;
   logic         acc_arith, acc_shift;
   logic [S-1:0] amt;
   logic [N:0]   add_r, sub_r;
   logic [N-1:0] arith_r, step_r;
   logic         arith_c, step_c;

   assign ready     = state_q == IDLE;
   assign acc_arith = ready & enable_arith & (opselect_in == 3'b001);
   assign acc_shift = ready & enable_shift & (opselect_in == 3'b000);
   assign amt       = operation_in[2] ? aluin2[S-1:0] : shift_number;
   assign aluout    = aluout_q;
   assign carry     = carry_q;
   assign out_valid = out_valid_q;

   // single-cycle arithmetic/logic result and carry for the presented operands
   always_comb begin
      add_r   = {1'b0, aluin1} + {1'b0, aluin2};
      sub_r   = {1'b0, aluin1} + {1'b0, ~aluin2} + {{N{1'b0}}, 1'b1};
      arith_r = '0;
      arith_c = 1'b0;
      case (operation_in)
         3'b000: {arith_c, arith_r} = add_r;
         3'b001: {arith_c, arith_r} = sub_r;
         3'b010: arith_r = aluin1 & aluin2;
         3'b011: arith_r = aluin1 | aluin2;
         3'b100: arith_r = aluin1 ^ aluin2;
         3'b101: arith_r = ~(aluin1 | aluin2);
         3'b110: arith_r = {{(N-1){1'b0}}, $signed(aluin1) < $signed(aluin2)};
         default: arith_r = {{(N-1){1'b0}}, aluin1 < aluin2};
      endcase
   end

   // one-bit move of the working register; step_c is the bit leaving (or wrapping, for ROL)
   always_comb begin
      case (sop_q)
         2'b00:   begin step_r = {work_q[N-2:0], 1'b0};      step_c = work_q[N-1]; end
         2'b01:   begin step_r = {1'b0, work_q[N-1:1]};      step_c = work_q[0];   end
         2'b10:   begin step_r = {work_q[N-1], work_q[N-1:1]}; step_c = work_q[0]; end
         default: begin step_r = {work_q[N-2:0], work_q[N-1]}; step_c = work_q[N-1]; end
      endcase
   end

   // next-state and result selection; outputs only move when out_valid is raised
   always_comb begin
      state_d     = state_q;
      aluout_d    = aluout_q;
      carry_d     = carry_q;
      out_valid_d = 1'b0;
      work_d      = work_q;
      cnt_d       = cnt_q;
      sop_d       = sop_q;
      case (state_q)
         IDLE: begin
            if (acc_arith) begin
               aluout_d    = arith_r;
               carry_d     = arith_c;
               out_valid_d = 1'b1;
            end else if (acc_shift) begin
               if (amt == '0) begin
                  aluout_d    = aluin1;
                  carry_d     = 1'b0;
                  out_valid_d = 1'b1;
               end else begin
                  work_d  = aluin1;
                  cnt_d   = amt;
                  sop_d   = operation_in[1:0];
                  state_d = SHIFT;
               end
            end
         end
         default: begin
            work_d = step_r;
            cnt_d  = cnt_q - 1'b1;
            if (cnt_q == S'(1)) begin
               aluout_d    = step_r;
               carry_d     = step_c;
               out_valid_d = 1'b1;
               state_d     = IDLE;
            end
         end
      endcase
   end

   // state registers with synchronous reset that also aborts a shift in flight
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         aluout_q    <= '0;
         carry_q     <= 1'b0;
         out_valid_q <= 1'b0;
         work_q      <= '0;
         cnt_q       <= '0;
         sop_q       <= '0;
      end else begin
         state_q     <= state_d;
         aluout_q    <= aluout_d;
         carry_q     <= carry_d;
         out_valid_q <= out_valid_d;
         work_q      <= work_d;
         cnt_q       <= cnt_d;
         sop_q       <= sop_d;
      end
   end
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: table vectors, corner sequences and randomized requests against a closed-form model
module tb_alu_exec_unit;
   logic        clock, reset, enable_arith, enable_shift;
   logic [31:0] aluin1, aluin2;
   logic [2:0]  operation_in, opselect_in;
   logic [4:0]  shift_number;
   logic        ready, carry, out_valid;
   logic [31:0] aluout;
   int errors = 0;
   int checks = 0;

   alu_exec_unit #(.N(32), .S(5)) dut (
      .clock(clock), .reset(reset), .enable_arith(enable_arith), .enable_shift(enable_shift),
      .aluin1(aluin1), .aluin2(aluin2), .operation_in(operation_in), .opselect_in(opselect_in),
      .shift_number(shift_number), .ready(ready), .aluout(aluout), .carry(carry), .out_valid(out_valid)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      string       nm;
      logic [2:0]  os;
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  sn;
      logic [31:0] ea;
      logic        ec;
   } vec_t;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic idle_inputs();
      enable_arith = 1'b0;
      enable_shift = 1'b0;
   endtask

   function automatic void model(input logic [2:0] os, input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [4:0] sn,
                                 output logic [31:0] r, output logic c);
      int n;
      logic [32:0] wide;
      r = 32'h0;
      c = 1'b0;
      if (os == 3'b001) begin
         case (op)
            3'd0: begin wide = {1'b0, a} + {1'b0, b}; r = wide[31:0]; c = wide[32]; end
            3'd1: begin r = a - b; c = (a >= b); end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = ~(a | b);
            3'd6: r = {31'b0, $signed(a) < $signed(b)};
            default: r = {31'b0, a < b};
         endcase
      end else begin
         n = op[2] ? int'(b[4:0]) : int'(sn);
         if (n == 0) r = a;
         else case (op[1:0])
            2'd0: begin r = a << n; c = a[32-n]; end
            2'd1: begin r = a >> n; c = a[n-1]; end
            2'd2: begin r = $signed(a) >>> n; c = a[n-1]; end
            default: begin r = (a << n) | (a >> (32 - n)); c = a[32-n]; end
         endcase
      end
   endfunction

   task automatic run_req(input string nm, input logic [2:0] os, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] sn, input logic [31:0] ea, input logic ec);
      int n;
      n = (os == 3'b000) ? (op[2] ? int'(b[4:0]) : int'(sn)) : 0;
      chk({nm, " ready_before"}, 64'(ready), 64'd1);
      opselect_in  = os;
      operation_in = op;
      aluin1       = a;
      aluin2       = b;
      shift_number = sn;
      enable_arith = (os == 3'b001);
      enable_shift = (os == 3'b000);
      tick();
      idle_inputs();
      aluin1       = ~a;
      aluin2       = ~b;
      operation_in = ~op;
      shift_number = ~sn;
      if (n > 0) begin
         chk({nm, " busy_E0"}, 64'({ready, out_valid}), 64'd0);
         for (int k = 1; k < n; k++) begin
            tick();
            chk({nm, " busy"}, 64'({ready, out_valid}), 64'd0);
         end
         tick();
      end
      chk({nm, " result"}, 64'({aluout, carry, out_valid, ready}), 64'({ea, ec, 1'b1, 1'b1}));
      tick();
      chk({nm, " hold"}, 64'({aluout, carry, out_valid}), 64'({ea, ec, 1'b0}));
   endtask

   vec_t vecs[$];
   logic [31:0] er;
   logic        ec;
   logic [2:0]  ros, rop;
   logic [31:0] ra, rb;
   logic [4:0]  rsn;

   initial begin
      vecs.push_back('{"add_wrap", 3'b001, 3'b000, 32'hFFFFFFFF, 32'h00000001, 5'd0, 32'h00000000, 1'b1});
      vecs.push_back('{"sub_borrow", 3'b001, 3'b001, 32'd5, 32'd7, 5'd0, 32'hFFFFFFFE, 1'b0});
      vecs.push_back('{"sub_noborrow", 3'b001, 3'b001, 32'd7, 32'd5, 5'd0, 32'h00000002, 1'b1});
      vecs.push_back('{"and", 3'b001, 3'b010, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd0, 32'h00F000F0, 1'b0});
      vecs.push_back('{"or", 3'b001, 3'b011, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd0, 32'hFFF0FFF0, 1'b0});
      vecs.push_back('{"xor", 3'b001, 3'b100, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd0, 32'hFF00FF00, 1'b0});
      vecs.push_back('{"nor", 3'b001, 3'b101, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd0, 32'h000F000F, 1'b0});
      vecs.push_back('{"slt", 3'b001, 3'b110, 32'h80000000, 32'h00000001, 5'd0, 32'h00000001, 1'b0});
      vecs.push_back('{"sltu", 3'b001, 3'b111, 32'h80000000, 32'h00000001, 5'd0, 32'h00000000, 1'b0});
      vecs.push_back('{"sra4", 3'b000, 3'b010, 32'h80000018, 32'h0, 5'd4, 32'hF8000001, 1'b1});
      vecs.push_back('{"rol_reg1", 3'b000, 3'b111, 32'h80000001, 32'h00000001, 5'd0, 32'h00000003, 1'b1});
      vecs.push_back('{"sll0", 3'b000, 3'b000, 32'h12345678, 32'h0, 5'd0, 32'h12345678, 1'b0});
      vecs.push_back('{"sll1", 3'b000, 3'b000, 32'h80000001, 32'h0, 5'd1, 32'h00000002, 1'b1});
      vecs.push_back('{"srl2", 3'b000, 3'b001, 32'h00000006, 32'h0, 5'd2, 32'h00000001, 1'b1});

      reset = 1'b1;
      idle_inputs();
      opselect_in  = 3'b001;
      operation_in = 3'b000;
      aluin1       = 32'hFFFFFFFF;
      aluin2       = 32'h1;
      shift_number = 5'd0;
      enable_arith = 1'b1;
      tick();
      tick();
      chk("reset_state", 64'({ready, aluout, carry, out_valid}), 64'({1'b1, 32'h0, 1'b0, 1'b0}));
      reset = 1'b0;
      idle_inputs();
      tick();
      chk("post_reset_idle", 64'({ready, aluout, out_valid}), 64'({1'b1, 32'h0, 1'b0}));

      foreach (vecs[i]) run_req(vecs[i].nm, vecs[i].os, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sn, vecs[i].ea, vecs[i].ec);

      opselect_in = 3'b001;
      enable_arith = 1'b1;
      operation_in = 3'b001; aluin1 = 32'd5; aluin2 = 32'd7;
      tick();
      chk("b2b_sub", 64'({aluout, carry, out_valid, ready}), 64'({32'hFFFFFFFE, 1'b0, 1'b1, 1'b1}));
      operation_in = 3'b110; aluin1 = 32'h80000000; aluin2 = 32'h1;
      tick();
      chk("b2b_slt", 64'({aluout, carry, out_valid}), 64'({32'h1, 1'b0, 1'b1}));
      operation_in = 3'b111;
      tick();
      chk("b2b_sltu", 64'({aluout, carry, out_valid}), 64'({32'h0, 1'b0, 1'b1}));
      idle_inputs();
      tick();
      chk("b2b_end", 64'(out_valid), 64'd0);

      opselect_in = 3'b000; operation_in = 3'b001; aluin1 = 32'hFFFFFFFF; shift_number = 5'd31;
      enable_shift = 1'b1;
      tick();
      enable_shift = 1'b0;
      enable_arith = 1'b1; opselect_in = 3'b001; operation_in = 3'b000; aluin1 = 32'h1; aluin2 = 32'h2;
      chk("srl31_E0", 64'({ready, out_valid}), 64'd0);
      for (int k = 1; k < 31; k++) begin
         tick();
         chk("srl31_busy", 64'({ready, out_valid, aluout}), 64'({1'b0, 1'b0, 32'h0}));
      end
      tick();
      chk("srl31_result", 64'({aluout, carry, out_valid, ready}), 64'({32'h1, 1'b1, 1'b1, 1'b1}));
      tick();
      chk("held_add_E32", 64'({aluout, carry, out_valid}), 64'({32'h3, 1'b0, 1'b1}));
      opselect_in = 3'b011;
      tick();
      chk("opsel011_noop", 64'({aluout, carry, out_valid}), 64'({32'h3, 1'b0, 1'b0}));
      idle_inputs();
      tick();

      opselect_in = 3'b000; operation_in = 3'b000; aluin1 = 32'h1; shift_number = 5'd10;
      enable_shift = 1'b1;
      tick();
      idle_inputs();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("abort_reset", 64'({aluout, carry, out_valid, ready}), 64'({32'h0, 1'b0, 1'b0, 1'b1}));
      for (int k = 0; k < 10; k++) begin
         tick();
         chk("abort_quiet", 64'({out_valid, ready}), 64'({1'b0, 1'b1}));
      end
      run_req("add_after_abort", 3'b001, 3'b000, 32'd100, 32'd23, 5'd0, 32'd123, 1'b0);

      for (int i = 0; i < 150; i++) begin
         ros = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'b001;
         rop = 3'($urandom_range(0, 7));
         ra  = $urandom;
         rb  = $urandom;
         rsn = 5'($urandom_range(0, 31));
         model(ros, rop, ra, rb, rsn, er, ec);
         run_req("rand", ros, rop, ra, rb, rsn, er, ec);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
